// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer: counter encodings,
// sweep FSM states and the 2-bit saturating counter update.
package btb_pkg;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_SWEEP = 1'b1
  } btb_state_e;

  // Taken counts up toward 3, not-taken counts down toward 0; never wraps.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != 2'b11) nxt = ctr + 2'b01;
    end else begin
      if (ctr != 2'b00) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_sweep_ctrl.sv
// Invalidation sweep sequencer: walks every BTB index once (DEPTH cycles),
// clearing one valid bit per cycle; a Flush during the sweep restarts it at 0.
module btb_sweep_ctrl
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  ClrEn,
  output logic [INDEX_BITS-1:0] ClrIdx
);

  btb_state_e            state_q;
  logic [INDEX_BITS-1:0] ptr_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= BTB_IDLE;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        BTB_IDLE: begin
          if (Flush) begin
            state_q <= BTB_SWEEP;
            ptr_q   <= '0;
          end
        end
        BTB_SWEEP: begin
          if (Flush) begin
            ptr_q <= '0;
          end else if (&ptr_q) begin
            state_q <= BTB_IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= BTB_IDLE;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  assign Busy   = (state_q == BTB_SWEEP);
  assign ClrEn  = Busy;
  assign ClrIdx = ptr_q;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency lookup of FetchPC, trained on the clock edge
// by execute; updates are dropped while a sweep is busy. Optional BTB_BYPASS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] FetchPC,
  output logic [31:0] SuperData,
  output logic        SuperSel,
  input  logic        UpdEn,
  input  logic [31:0] UpdPC,
  input  logic [31:0] UpdTarget,
  input  logic        UpdTaken,
  input  logic        Flush,
  output logic        Busy
);

  localparam int DEPTH    = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                valid_q [DEPTH];
  logic [1:0]          ctr_q   [DEPTH];
  logic [TAG_BITS-1:0] tag_q   [DEPTH];
  logic [31:0]         tgt_q   [DEPTH];

  logic                  clr_en;
  logic [INDEX_BITS-1:0] clr_idx;

  btb_sweep_ctrl #(
    .INDEX_BITS(INDEX_BITS)
  ) u_sweep (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Flush (Flush),
    .Busy  (Busy),
    .ClrEn (clr_en),
    .ClrIdx(clr_idx)
  );

  logic [INDEX_BITS-1:0] fetch_idx, upd_idx;
  logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
  logic                  unused_pc_lsbs;

  assign fetch_idx      = FetchPC[INDEX_BITS+1:2];
  assign fetch_tag      = FetchPC[31:INDEX_BITS+2];
  assign upd_idx        = UpdPC[INDEX_BITS+1:2];
  assign upd_tag        = UpdPC[31:INDEX_BITS+2];
  assign unused_pc_lsbs = ^{FetchPC[1:0], UpdPC[1:0]};

  logic       upd_act, upd_hit, upd_train, upd_alloc, upd_wr_tgt;
  logic [1:0] upd_ctr_d;

  assign upd_act    = UpdEn && !Busy;
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_train  = upd_act && upd_hit;
  assign upd_alloc  = upd_act && !upd_hit && UpdTaken;
  assign upd_wr_tgt = upd_alloc || (upd_train && UpdTaken);
  assign upd_ctr_d  = upd_hit ? ctr_update(ctr_q[upd_idx], UpdTaken) : CTR_WEAK_TAKEN;

  // Sweep clears and training never collide: training is suppressed while Busy.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else begin
      if (clr_en) begin
        valid_q[clr_idx] <= 1'b0;
      end
      if (upd_train || upd_alloc) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= upd_ctr_d;
      end
    end
  end

  // Tag and target are only ever read qualified by valid, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (upd_alloc) begin
      tag_q[upd_idx] <= upd_tag;
    end
    if (upd_wr_tgt) begin
      tgt_q[upd_idx] <= UpdTarget;
    end
  end

  logic        look_hit;
  logic [1:0]  look_ctr;
  logic [31:0] look_tgt;

`ifdef BTB_BYPASS_EN
  logic byp;

  // A miss + not-taken update leaves the entry untouched, so it needs no bypass.
  assign byp = upd_act && (upd_idx == fetch_idx) && (upd_tag == fetch_tag)
               && (upd_hit || UpdTaken);

  always_comb begin
    look_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    look_ctr = ctr_q[fetch_idx];
    look_tgt = tgt_q[fetch_idx];
    if (byp) begin
      look_hit = 1'b1;
      look_ctr = upd_ctr_d;
      look_tgt = upd_wr_tgt ? UpdTarget : tgt_q[fetch_idx];
    end
  end
`else
  always_comb begin
    look_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    look_ctr = ctr_q[fetch_idx];
    look_tgt = tgt_q[fetch_idx];
  end
`endif

  assign SuperSel  = look_hit && look_ctr[1] && !Busy;
  assign SuperData = look_hit ? look_tgt : 32'h0;

endmodule
